// File: rtl/hamnhan_axi_master.sv
// AXI4-Lite master that drives a memory-mapped multiplier: writes A, B and START,
// polls DONE, then reads the product P back.
module hamnhan_axi_master #(
  parameter logic [31:0] BASE_ADDR = 32'h7C800000,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        error,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic [1:0]  M_AXI_RRESP
);

  localparam int unsigned PCW = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_GO, POLL, RD_P, FIN} state_t;

  state_t          state;
  logic [31:0]     opb_q;
  logic            aw_done;
  logic            w_done;
  logic [PCW-1:0]  poll_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      opb_q         <= 32'd0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      poll_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= 32'd0;
      error         <= 1'b0;
      M_AXI_AWADDR  <= 32'd0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'd0;
      M_AXI_WSTRB   <= 4'h0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= 32'd0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opb_q         <= op_b;
            busy          <= 1'b1;
            state         <= WR_A;
            M_AXI_AWADDR  <= BASE_ADDR;
            M_AXI_WDATA   <= op_a;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WSTRB   <= 4'hF;
          end
        end

        // AW and W retire independently; B is accepted only after both have.
        WR_A, WR_B, WR_GO: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            M_AXI_WSTRB  <= 4'h0;
            w_done       <= 1'b1;
          end
          if (!M_AXI_BREADY && (aw_done | aw_hs) && (w_done | w_hs))
            M_AXI_BREADY <= 1'b1;
          if (b_hs) begin
            M_AXI_BREADY <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              result <= 32'd0;
              error  <= 1'b1;
              done   <= 1'b1;
              state  <= FIN;
            end else if (state == WR_A) begin
              state         <= WR_B;
              M_AXI_AWADDR  <= BASE_ADDR + 32'h4;
              M_AXI_WDATA   <= opb_q;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_WSTRB   <= 4'hF;
            end else if (state == WR_B) begin
              state         <= WR_GO;
              M_AXI_AWADDR  <= BASE_ADDR + 32'h8;
              M_AXI_WDATA   <= 32'd1;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_WSTRB   <= 4'hF;
            end else begin
              state         <= POLL;
              poll_cnt      <= '0;
              M_AXI_ARADDR  <= BASE_ADDR + 32'h10;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end

        // Address phase first, then hold RREADY until the data beat lands.
        POLL, RD_P: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
          if (r_hs) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              result <= 32'd0;
              error  <= 1'b1;
              done   <= 1'b1;
              state  <= FIN;
            end else if (state == RD_P) begin
              result <= M_AXI_RDATA;
              error  <= 1'b0;
              done   <= 1'b1;
              state  <= FIN;
            end else if (M_AXI_RDATA[0]) begin
              state         <= RD_P;
              M_AXI_ARADDR  <= BASE_ADDR + 32'hC;
              M_AXI_ARVALID <= 1'b1;
            end else if (poll_cnt == PCW'(MAX_POLLS - 1)) begin
              result <= 32'd0;
              error  <= 1'b1;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              poll_cnt      <= poll_cnt + 1'b1;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamnhan_axi_master.sv
// Directed bench for hamnhan_axi_master with a behavioural AXI-Lite multiplier slave.
module tb_hamnhan_axi_master;

  localparam logic [31:0] BASE = 32'h7C800000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        busy, done, error;
  logic [31:0] result;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  hamnhan_axi_master #(.BASE_ADDR(BASE), .MAX_POLLS(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .error(error),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY), .M_AXI_RRESP(RRESP)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // slave configuration
  int          aw_delay = 0;
  int          done_after = 1;
  int          bad_b_idx = 0;
  logic [31:0] p_value = 32'd0;

  // slave state, logs and protocol monitors
  logic [31:0] aw_log [64];
  logic [31:0] w_log  [64];
  logic [31:0] ar_log [64];
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0;
  int awv_cyc = 0, wv_cyc = 0, ovl_bad = 0, strb_bad = 0;
  int aw_cnt = 0, job_wr = 0, poll_num = 0;
  bit aw_got, w_got, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] last_ar;

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    aw_got = 0; w_got = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    last_ar = 0;
    forever begin
      @(negedge clk);
      if (AWVALID) awv_cyc++;
      if (WVALID) wv_cyc++;
      if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) ovl_bad++;
      if (WSTRB !== (WVALID ? 4'hF : 4'h0)) strb_bad++;
      if (rst) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0;
      end else begin
        if (aw_hs) begin AWREADY = 0; aw_got = 1; aw_cnt = 0; end
        if (w_hs) begin WREADY = 0; w_got = 1; end
        if (b_hs) begin BVALID = 0; BRESP = 0; b_n++; end
        if (r_hs) begin RVALID = 0; RDATA = 0; end
        if (ar_hs) begin
          ARREADY = 0; RVALID = 1; RRESP = 0;
          if (last_ar == BASE + 32'h10) begin
            poll_num++;
            RDATA = (done_after != 0 && poll_num >= done_after) ? 32'd1 : 32'd0;
          end else begin
            RDATA = p_value;
          end
        end
        if (AWVALID && !AWREADY) begin
          if (aw_cnt >= aw_delay) begin
            AWREADY = 1;
            if (aw_n < 64) aw_log[aw_n] = AWADDR;
            aw_n++;
            if (AWADDR == BASE) job_wr = 0;
            if (AWADDR == BASE + 32'h8) poll_num = 0;
          end else aw_cnt++;
        end
        if (WVALID && !WREADY) begin
          WREADY = 1;
          if (w_n < 64) w_log[w_n] = WDATA;
          w_n++;
        end
        if (aw_got && w_got && !BVALID) begin
          job_wr++;
          BVALID = 1;
          BRESP = (job_wr == bad_b_idx) ? 2'b10 : 2'b00;
          aw_got = 0; w_got = 0;
        end
        if (ARVALID && !ARREADY && !RVALID) begin
          ARREADY = 1;
          last_ar = ARADDR;
          if (ar_n < 64) ar_log[ar_n] = ARADDR;
          ar_n++;
        end
      end
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the done pulse, checks its payload and that it lasts one cycle.
  task automatic finish_job(input string tag, input logic [31:0] exp_res, input logic exp_err);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check32({tag, "_done_seen"}, 32'(done), 32'd1);
    check32({tag, "_result"}, result, exp_res);
    check32({tag, "_error"}, 32'(error), 32'(exp_err));
    @(negedge clk);
    check32({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check32({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  int aw0, w0, ar0, b0, awc0, wvc0, n;

  initial begin
    // reset state
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_error", 32'(error), 32'd0);
    check32("rst_result", result, 32'd0);
    check32("rst_awvalid", 32'(AWVALID), 32'd0);
    check32("rst_wvalid", 32'(WVALID), 32'd0);
    check32("rst_arvalid", 32'(ARVALID), 32'd0);
    check32("rst_wstrb", 32'(WSTRB), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check32("idle_no_aw", 32'(aw_n), 32'd0);
    check32("idle_no_ar", 32'(ar_n), 32'd0);

    // 15*15 with DONE on 4th poll; a start pulse during POLL must be ignored
    done_after = 4; p_value = 32'd225;
    aw0 = aw_n; w0 = w_n; ar0 = ar_n;
    do_start(32'd15, 32'd15);
    check32("t1_busy", 32'(busy), 32'd1);
    n = 0;
    while (ARVALID !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check32("t1_poll_reached", 32'(ARVALID), 32'd1);
    do_start(32'd7, 32'd7);
    finish_job("t1", 32'd225, 1'b0);
    repeat (4) @(negedge clk);
    check32("t1_aw_count", 32'(aw_n - aw0), 32'd3);
    check32("t1_aw0", aw_log[aw0], 32'h7C800000);
    check32("t1_aw1", aw_log[aw0+1], 32'h7C800004);
    check32("t1_aw2", aw_log[aw0+2], 32'h7C800008);
    check32("t1_w0", w_log[w0], 32'd15);
    check32("t1_w1", w_log[w0+1], 32'd15);
    check32("t1_w2", w_log[w0+2], 32'd1);
    check32("t1_ar_count", 32'(ar_n - ar0), 32'd5);
    for (int i = 0; i < 4; i++) check32("t1_ar_poll", ar_log[ar0+i], 32'h7C800010);
    check32("t1_ar_p", ar_log[ar0+4], 32'h7C80000C);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3; done_after = 1; p_value = 32'd15;
    b0 = b_n; awc0 = awv_cyc; wvc0 = wv_cyc;
    do_start(32'd3, 32'd5);
    finish_job("t2", 32'd15, 1'b0);
    check32("t2_awvalid_cycles", 32'(awv_cyc - awc0), 32'd12);
    check32("t2_wvalid_cycles", 32'(wv_cyc - wvc0), 32'd3);
    check32("t2_b_count", 32'(b_n - b0), 32'd3);
    aw_delay = 0;

    // DONE never set: exactly 8 polls then timeout
    done_after = 0; p_value = 32'hDEAD;
    ar0 = ar_n;
    do_start(32'd4, 32'd4);
    finish_job("t3", 32'd0, 1'b1);
    check32("t3_ar_count", 32'(ar_n - ar0), 32'd8);
    check32("t3_ar_last", ar_log[ar0+7], 32'h7C800010);

    // bad BRESP on the B write: no START write, no reads
    bad_b_idx = 2; done_after = 1;
    aw0 = aw_n; ar0 = ar_n;
    do_start(32'd9, 32'd9);
    finish_job("t4", 32'd0, 1'b1);
    check32("t4_aw_count", 32'(aw_n - aw0), 32'd2);
    check32("t4_ar_count", 32'(ar_n - ar0), 32'd0);
    bad_b_idx = 0;

    // reset during RD_P, then a clean job
    done_after = 1; p_value = 32'd99;
    do_start(32'd9, 32'd11);
    n = 0;
    while (!(ARVALID === 1'b1 && ARADDR === 32'h7C80000C) && n < 200) begin @(negedge clk); n++; end
    check32("t5_rdp_reached", ARADDR, 32'h7C80000C);
    #1 rst = 1'b1;
    #1;
    check32("t5_rst_busy", 32'(busy), 32'd0);
    check32("t5_rst_arvalid", 32'(ARVALID), 32'd0);
    check32("t5_rst_araddr", ARADDR, 32'd0);
    check32("t5_rst_rready", 32'(RREADY), 32'd0);
    check32("t5_rst_awaddr", AWADDR, 32'd0);
    check32("t5_rst_wdata", WDATA, 32'd0);
    check32("t5_rst_done_err", {30'd0, done, error}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    done_after = 2; p_value = 32'd6;
    aw0 = aw_n; w0 = w_n; ar0 = ar_n;
    do_start(32'd2, 32'd3);
    finish_job("t5", 32'd6, 1'b0);
    check32("t5_aw_count", 32'(aw_n - aw0), 32'd3);
    check32("t5_w0", w_log[w0], 32'd2);
    check32("t5_w1", w_log[w0+1], 32'd3);
    check32("t5_w2", w_log[w0+2], 32'd1);
    check32("t5_ar_count", 32'(ar_n - ar0), 32'd3);
    check32("t5_ar_p", ar_log[ar0+2], 32'h7C80000C);

    check32("no_rw_overlap", 32'(ovl_bad), 32'd0);
    check32("wstrb_rule", 32'(strb_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamnhan_axi_master.md
HAMNHAN_AXI_MASTER -- requirements
Module: hamnhan_axi_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h7C800000, multiplier register base (A +0x0, B +0x4, START +0x8, P +0xC, DONE +0x10).
REQ-002 SHALL have parameter MAX_POLLS, default 1024, maximum DONE reads before timeout.
REQ-003 M_AXI_ACLK  in  1  single clock, all logic on rising edge.
REQ-004 M_AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request one multiply; sampled only in IDLE.
REQ-006 op_a  in  32  operand A, captured when start is accepted.
REQ-007 op_b  in  32  operand B, captured when start is accepted.
REQ-008 busy  out  1  high in every non-IDLE state.
REQ-009 done  out  1  one-cycle pulse at end of every accepted job (success or error).
REQ-010 result  out  32  product read from P; held until next done.
REQ-011 error  out  1  valid with done; 1 = bad response or timeout; held until next done.
REQ-012 M_AXI_AWADDR  out  32  write address.
REQ-013 M_AXI_AWVALID  out  1  write address valid.
REQ-014 M_AXI_AWREADY  in  1  write address ready.
REQ-015 M_AXI_WDATA  out  32  write data.
REQ-016 M_AXI_WSTRB  out  4  byte strobes; 4'hF while WVALID, else 4'h0.
REQ-017 M_AXI_WVALID  out  1  write data valid.
REQ-018 M_AXI_WREADY  in  1  write data ready.
REQ-019 M_AXI_BVALID  in  1  write response valid.
REQ-020 M_AXI_BREADY  out  1  write response ready.
REQ-021 M_AXI_BRESP  in  2  write response; nonzero = error.
REQ-022 M_AXI_ARADDR  out  32  read address.
REQ-023 M_AXI_ARVALID  out  1  read address valid.
REQ-024 M_AXI_ARREADY  in  1  read address ready.
REQ-025 M_AXI_RDATA  in  32  read data.
REQ-026 M_AXI_RVALID  in  1  read data valid.
REQ-027 M_AXI_RREADY  out  1  read data ready.
REQ-028 M_AXI_RRESP  in  2  read response; nonzero = error.

Function
REQ-029 FSM states SHALL be IDLE, WR_A, WR_B, WR_GO, POLL, RD_P, FIN; sequence IDLE->WR_A->WR_B->WR_GO->POLL->RD_P->FIN->IDLE.
REQ-030 start=1 in IDLE SHALL capture op_a/op_b and enter WR_A; start while busy SHALL be ignored.
REQ-031 Each write state SHALL assert AWVALID and WVALID together in the first state cycle, AWADDR/WDATA stable (WR_A: BASE+0/op_a, WR_B: BASE+4/op_b, WR_GO: BASE+8/32'd1).
REQ-032 AWVALID and WVALID SHALL each drop the cycle after their own READY handshake, independently; never drop before handshake.
REQ-033 BREADY SHALL assert once both AW and W handshakes are complete and drop after the BVALID&BREADY cycle; only then the FSM advances.
REQ-034 Each read (POLL: BASE+0x10, RD_P: BASE+0xC) SHALL hold ARVALID/ARADDR until ARREADY, then assert RREADY until RVALID&RREADY.
REQ-035 POLL: RDATA[0]=1 -> RD_P; RDATA[0]=0 -> issue new DONE read, incrementing a poll counter.
REQ-036 Poll counter reaching MAX_POLLS with DONE still 0 SHALL go to FIN with error=1, result=0.
REQ-037 BRESP or RRESP nonzero in any state SHALL go to FIN with error=1, result=0, no further transactions.
REQ-038 RD_P success SHALL register result=RDATA, error=0, then FIN; FIN asserts done for exactly one cycle and returns to IDLE.
REQ-039 At most one outstanding transaction at any time; no read and write overlap.

Reset
REQ-040 M_AXI_ARESET=1 SHALL immediately force IDLE and all outputs to 0 (busy, done, error, result, all VALID/READY, addresses, WDATA, WSTRB), including mid-transaction.
REQ-041 After reset release the block SHALL issue no transaction until start.

Verification
REQ-042 op_a=15, op_b=15, slave DONE=1 on 4th poll, P=225 -> writes 15@0x7C800000, 15@0x7C800004, 1@0x7C800008, 4 reads @0x7C800010, 1 read @0x7C80000C, done pulse, result=225, error=0.
REQ-043 Slave delays AWREADY 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single B handshake per write.
REQ-044 MAX_POLLS=8, DONE never set -> exactly 8 DONE reads, no P read, done pulse with error=1, result=0.
REQ-045 BRESP=2'b10 on B write -> no START write, done with error=1.
REQ-046 start pulsed during POLL -> ignored; reset asserted during RD_P -> all outputs 0 same cycle, next start runs a full clean sequence.
